clic_target_arb: RTL and testbench

CLIC_TARGET_ARB -- requirements
Module: clic_target_arb

---
 rtl/clic_pkg.sv | 20 ++
 rtl/clic_arb_tree.sv | 59 +++++
 rtl/clic_target_arb.sv | 154 +++++++++++++++
 tb/tb_clic_target_arb.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clic_pkg.sv
// Shared CLIC arbitration types: arbiter FSM state encoding and the (mode, level)
// priority key compare used by the winner tree and the preemption check.
package clic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_KILL  = 2'd2
  } arb_state_e;

  localparam int unsigned KeyWidth = 32;

  // Key layout is {mode, level} zero-extended, so mode dominates and level breaks ties.
  typedef logic [KeyWidth-1:0] prio_key_t;

  function automatic logic prio_gt(input prio_key_t a, input prio_key_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/clic_arb_tree.sv
// Combinational winner search over N_TGT requesters as a binary max-tree.
// Equal keys prefer pref_i set, then the lower index.
module clic_arb_tree
  import clic_pkg::*;
#(
  parameter  int unsigned N_TGT    = 2,
  localparam int unsigned TgtWidth = $clog2(N_TGT)
) (
  input  logic      [N_TGT-1:0]    valid_i,
  input  prio_key_t [N_TGT-1:0]    key_i,
  input  logic      [N_TGT-1:0]    pref_i,
  output logic                     any_valid_o,
  output logic      [TgtWidth-1:0] win_idx_o
);

  localparam int unsigned Leaves = 1 << TgtWidth;

  // Heap layout: node 1 is the root, leaves occupy Leaves..2*Leaves-1.
  logic                node_v [1:2*Leaves-1];
  prio_key_t           node_k [1:2*Leaves-1];
  logic                node_p [1:2*Leaves-1];
  logic [TgtWidth-1:0] node_i [1:2*Leaves-1];

  always_comb begin
    for (int n = 1; n < 2*Leaves; n++) begin
      node_v[n] = 1'b0;
      node_k[n] = '0;
      node_p[n] = 1'b0;
      node_i[n] = '0;
    end
    for (int l = 0; l < Leaves; l++) begin
      node_i[Leaves+l] = TgtWidth'(l);
      if (l < N_TGT) begin
        node_v[Leaves+l] = valid_i[l];
        node_k[Leaves+l] = key_i[l];
        node_p[Leaves+l] = pref_i[l];
      end
    end
    for (int n = Leaves-1; n >= 1; n--) begin
      if (node_v[2*n+1] &&
          (!node_v[2*n] ||
           prio_gt(node_k[2*n+1], node_k[2*n]) ||
           ((node_k[2*n+1] == node_k[2*n]) && node_p[2*n+1] && !node_p[2*n]))) begin
        node_v[n] = node_v[2*n+1];
        node_k[n] = node_k[2*n+1];
        node_p[n] = node_p[2*n+1];
        node_i[n] = node_i[2*n+1];
      end else begin
        node_v[n] = node_v[2*n];
        node_k[n] = node_k[2*n];
        node_p[n] = node_p[2*n];
        node_i[n] = node_i[2*n];
      end
    end
    any_valid_o = node_v[1];
    win_idx_o   = node_i[1];
  end

endmodule

// File: rtl/clic_target_arb.sv
// Arbitrates N_TGT CLIC target requests onto one core IRQ port with preemption via kill.
// Define CLIC_TARGET_ARB_RR_EN for round-robin tie-break; otherwise the lowest index wins ties.
//
// state    | meaning
// ST_IDLE  | no offer; winner of the current requests is latched next edge
// ST_OFFER | latched irq presented to the core, waiting for ready
// ST_KILL  | offer still presented, kill requested from the core, waiting for ack or ready
module clic_target_arb
  import clic_pkg::*;
#(
  parameter  int unsigned N_TGT     = 2,
  parameter  int unsigned N_SOURCE  = 256,
  parameter  int unsigned PrioWidth = 8,
  parameter  int unsigned ModeWidth = 2,
  localparam int unsigned SrcWidth  = $clog2(N_SOURCE),
  localparam int unsigned TgtWidth  = $clog2(N_TGT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_TGT-1:0]                    tgt_valid_i,
  input  logic [N_TGT-1:0][SrcWidth-1:0]      tgt_id_i,
  input  logic [N_TGT-1:0][PrioWidth-1:0]     tgt_max_i,
  input  logic [N_TGT-1:0][ModeWidth-1:0]     tgt_mode_i,
  output logic [N_TGT-1:0]                    tgt_ready_o,
  input  logic [N_TGT-1:0]                    tgt_kill_req_i,
  output logic [N_TGT-1:0]                    tgt_kill_ack_o,
  output logic                                irq_valid_o,
  input  logic                                irq_ready_i,
  output logic [SrcWidth-1:0]                 irq_id_o,
  output logic [PrioWidth-1:0]                irq_max_o,
  output logic [ModeWidth-1:0]                irq_mode_o,
  output logic [TgtWidth-1:0]                 irq_tgt_o,
  output logic                                irq_kill_req_o,
  input  logic                                irq_kill_ack_i
);

  arb_state_e          state_q;
  prio_key_t [N_TGT-1:0] tgt_key;
  prio_key_t           cur_key;
  logic [N_TGT-1:0]    pref;
  logic                any_valid;
  logic [TgtWidth-1:0] win_idx;
  logic                preempt;
  logic                g_valid;
  logic                g_kill;
  logic                hs;
  logic                ready_grant;
  logic                kack_grant;

  always_comb begin
    for (int t = 0; t < N_TGT; t++) begin
      tgt_key[t] = prio_key_t'({tgt_mode_i[t], tgt_max_i[t]});
    end
  end

  assign cur_key = prio_key_t'({irq_mode_o, irq_max_o});

`ifdef CLIC_TARGET_ARB_RR_EN
  logic [TgtWidth-1:0] rr_ptr_q;

  always_comb begin
    for (int t = 0; t < N_TGT; t++) begin
      pref[t] = (TgtWidth'(t) >= rr_ptr_q);
    end
  end

  // Pointer moves past the granted target only when the core actually takes the irq.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (irq_tgt_o == TgtWidth'(N_TGT-1)) ? '0 : irq_tgt_o + 1'b1;
    end
  end
`else
  assign pref = '0;
`endif

  clic_arb_tree #(
    .N_TGT (N_TGT)
  ) u_tree (
    .valid_i     (tgt_valid_i),
    .key_i       (tgt_key),
    .pref_i      (pref),
    .any_valid_o (any_valid),
    .win_idx_o   (win_idx)
  );

  // Only a strictly higher competitor preempts; an equal one waits for the next round.
  always_comb begin
    preempt = 1'b0;
    for (int t = 0; t < N_TGT; t++) begin
      if ((TgtWidth'(t) != irq_tgt_o) && tgt_valid_i[t] && prio_gt(tgt_key[t], cur_key)) begin
        preempt = 1'b1;
      end
    end
  end

  assign g_valid     = tgt_valid_i[irq_tgt_o];
  assign g_kill      = tgt_kill_req_i[irq_tgt_o];
  assign hs          = irq_valid_o & irq_ready_i;
  assign ready_grant = hs & ((state_q == ST_OFFER) | ((state_q == ST_KILL) & g_valid));
  assign kack_grant  = (state_q == ST_KILL) & irq_kill_req_o & irq_kill_ack_i & ~irq_ready_i & g_kill;

  assign tgt_ready_o    = (ready_grant & ~rst_i) ? (N_TGT'(1) << irq_tgt_o) : '0;
  assign tgt_kill_ack_o = (kack_grant  & ~rst_i) ? (N_TGT'(1) << irq_tgt_o) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      irq_valid_o    <= 1'b0;
      irq_kill_req_o <= 1'b0;
      irq_id_o       <= '0;
      irq_max_o      <= '0;
      irq_mode_o     <= '0;
      irq_tgt_o      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            state_q     <= ST_OFFER;
            irq_valid_o <= 1'b1;
            irq_tgt_o   <= win_idx;
            irq_id_o    <= tgt_id_i[win_idx];
            irq_max_o   <= tgt_max_i[win_idx];
            irq_mode_o  <= tgt_mode_i[win_idx];
          end
        end
        ST_OFFER: begin
          if (hs || !g_valid) begin
            state_q     <= ST_IDLE;
            irq_valid_o <= 1'b0;
          end else if (g_kill || preempt) begin
            state_q        <= ST_KILL;
            irq_kill_req_o <= 1'b1;
          end
        end
        ST_KILL: begin
          if (hs || irq_kill_ack_i) begin
            state_q        <= ST_IDLE;
            irq_valid_o    <= 1'b0;
            irq_kill_req_o <= 1'b0;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          irq_valid_o    <= 1'b0;
          irq_kill_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clic_target_arb.sv
// Directed bench for clic_target_arb: stimulus pushes expected grants, a monitor
// pops and compares them each time irq_valid_o rises; handshake side effects checked inline.
module tb_clic_target_arb;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0]      tgt_valid_i;
  logic [1:0][7:0] tgt_id_i;
  logic [1:0][7:0] tgt_max_i;
  logic [1:0][1:0] tgt_mode_i;
  logic [1:0]      tgt_ready_o;
  logic [1:0]      tgt_kill_req_i;
  logic [1:0]      tgt_kill_ack_o;
  logic            irq_valid_o;
  logic            irq_ready_i;
  logic [7:0]      irq_id_o;
  logic [7:0]      irq_max_o;
  logic [1:0]      irq_mode_o;
  logic [0:0]      irq_tgt_o;
  logic            irq_kill_req_o;
  logic            irq_kill_ack_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [0:0] tgt;
    logic [7:0] id;
    logic [7:0] max;
    logic [1:0] mode;
  } exp_t;

  exp_t exp_q[$];

  clic_target_arb dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .tgt_valid_i    (tgt_valid_i),
    .tgt_id_i       (tgt_id_i),
    .tgt_max_i      (tgt_max_i),
    .tgt_mode_i     (tgt_mode_i),
    .tgt_ready_o    (tgt_ready_o),
    .tgt_kill_req_i (tgt_kill_req_i),
    .tgt_kill_ack_o (tgt_kill_ack_o),
    .irq_valid_o    (irq_valid_o),
    .irq_ready_i    (irq_ready_i),
    .irq_id_o       (irq_id_o),
    .irq_max_o      (irq_max_o),
    .irq_mode_o     (irq_mode_o),
    .irq_tgt_o      (irq_tgt_o),
    .irq_kill_req_o (irq_kill_req_o),
    .irq_kill_ack_i (irq_kill_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_tgt(input int t, input logic v, input logic [7:0] id,
                         input logic [7:0] max, input logic [1:0] mode);
    tgt_valid_i[t] = v;
    tgt_id_i[t]    = id;
    tgt_max_i[t]   = max;
    tgt_mode_i[t]  = mode;
  endtask

  task automatic clr_all();
    tgt_valid_i    = '0;
    tgt_id_i       = '0;
    tgt_max_i      = '0;
    tgt_mode_i     = '0;
    tgt_kill_req_i = '0;
  endtask

  task automatic push(input logic [0:0] t, input logic [7:0] id,
                      input logic [7:0] max, input logic [1:0] mode);
    exp_t e;
    e.tgt  = t;
    e.id   = id;
    e.max  = max;
    e.mode = mode;
    exp_q.push_back(e);
  endtask

  // Core accepts the current offer; checks the target ready pulse and the bubble after it.
  task automatic grant_hs(input logic [1:0] exp_rdy, input string nm);
    irq_ready_i = 1'b1;
    #1;
    chk({nm, "_ready"}, 32'(tgt_ready_o), 32'(exp_rdy));
    chk({nm, "_kack"}, 32'(tgt_kill_ack_o), 32'd0);
    step();
    irq_ready_i = 1'b0;
    clr_all();
    chk({nm, "_bubble"}, 32'(irq_valid_o), 32'd0);
  endtask

  logic prev_v = 1'b0;

  always @(negedge clk_i) begin
    exp_t e;
    if (irq_valid_o === 1'b1 && prev_v !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got tgt=%0d id=0x%0h expected no grant", irq_tgt_o, irq_id_o);
      end else begin
        e = exp_q.pop_front();
        chk("grant_tgt",  32'(irq_tgt_o),  32'(e.tgt));
        chk("grant_id",   32'(irq_id_o),   32'(e.id));
        chk("grant_max",  32'(irq_max_o),  32'(e.max));
        chk("grant_mode", 32'(irq_mode_o), 32'(e.mode));
      end
    end
    prev_v = irq_valid_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:0] rr_t;
    rst_i          = 1'b1;
    irq_ready_i    = 1'b0;
    irq_kill_ack_i = 1'b0;
    clr_all();
    step();
    step();
    chk("rst_valid", 32'(irq_valid_o),    32'd0);
    chk("rst_kill",  32'(irq_kill_req_o), 32'd0);
    chk("rst_id",    32'(irq_id_o),       32'd0);
    chk("rst_ready", 32'(tgt_ready_o),    32'd0);
    rst_i = 1'b0;
    step();

    // single request, one-cycle latency
    set_tgt(0, 1'b1, 8'd5, 8'h40, 2'd3);
    push(1'b0, 8'd5, 8'h40, 2'd3);
    step();
    chk("single_valid", 32'(irq_valid_o), 32'd1);
    grant_hs(2'b01, "single");

    // level decides within equal mode; mode dominates level
    set_tgt(0, 1'b1, 8'd1, 8'h10, 2'd3);
    set_tgt(1, 1'b1, 8'd2, 8'h20, 2'd3);
    push(1'b1, 8'd2, 8'h20, 2'd3);
    step();
    grant_hs(2'b10, "prio_level");
    set_tgt(0, 1'b1, 8'd3, 8'h01, 2'd3);
    set_tgt(1, 1'b1, 8'd4, 8'hFF, 2'd1);
    push(1'b0, 8'd3, 8'h01, 2'd3);
    step();
    grant_hs(2'b01, "prio_mode");

    // preemption by higher-level target
    set_tgt(0, 1'b1, 8'd7, 8'h10, 2'd3);
    push(1'b0, 8'd7, 8'h10, 2'd3);
    step();
    chk("pre_offer_nokill", 32'(irq_kill_req_o), 32'd0);
    set_tgt(1, 1'b1, 8'd9, 8'h80, 2'd3);
    step();
    chk("pre_kill_req", 32'(irq_kill_req_o), 32'd1);
    chk("pre_kill_valid", 32'(irq_valid_o), 32'd1);
    chk("pre_kill_tgt", 32'(irq_tgt_o), 32'd0);
    irq_kill_ack_i = 1'b1;
    #1;
    chk("pre_tgt_kack", 32'(tgt_kill_ack_o), 32'd0);
    push(1'b1, 8'd9, 8'h80, 2'd3);
    step();
    irq_kill_ack_i = 1'b0;
    chk("pre_bubble_valid", 32'(irq_valid_o), 32'd0);
    chk("pre_bubble_kill", 32'(irq_kill_req_o), 32'd0);
    step();
    grant_hs(2'b10, "pre_grant");

    // ready and kill ack together resolve as a handshake
    set_tgt(0, 1'b1, 8'd6, 8'h22, 2'd2);
    push(1'b0, 8'd6, 8'h22, 2'd2);
    step();
    tgt_kill_req_i = 2'b01;
    step();
    chk("kvr_kill_req", 32'(irq_kill_req_o), 32'd1);
    irq_ready_i    = 1'b1;
    irq_kill_ack_i = 1'b1;
    #1;
    chk("kvr_ready", 32'(tgt_ready_o), 32'd1);
    chk("kvr_kack", 32'(tgt_kill_ack_o), 32'd0);
    step();
    irq_ready_i    = 1'b0;
    irq_kill_ack_i = 1'b0;
    clr_all();
    chk("kvr_idle_valid", 32'(irq_valid_o), 32'd0);
    chk("kvr_idle_kill", 32'(irq_kill_req_o), 32'd0);

    // target kill request acknowledged back to target 1
    set_tgt(1, 1'b1, 8'd8, 8'h30, 2'd1);
    push(1'b1, 8'd8, 8'h30, 2'd1);
    step();
    tgt_kill_req_i = 2'b10;
    step();
    chk("kack_kill_req", 32'(irq_kill_req_o), 32'd1);
    irq_kill_ack_i = 1'b1;
    #1;
    chk("kack_tgt", 32'(tgt_kill_ack_o), 32'd2);
    chk("kack_no_ready", 32'(tgt_ready_o), 32'd0);
    step();
    irq_kill_ack_i = 1'b0;
    clr_all();
    chk("kack_idle", 32'(irq_valid_o), 32'd0);

    // withdraw during offer
    set_tgt(0, 1'b1, 8'd12, 8'h44, 2'd3);
    push(1'b0, 8'd12, 8'h44, 2'd3);
    step();
    tgt_valid_i[0] = 1'b0;
    step();
    chk("wd_valid", 32'(irq_valid_o), 32'd0);
    clr_all();

    // withdraw during kill: hold kill until ack
    set_tgt(0, 1'b1, 8'd14, 8'h50, 2'd2);
    push(1'b0, 8'd14, 8'h50, 2'd2);
    step();
    tgt_kill_req_i = 2'b01;
    step();
    tgt_valid_i[0] = 1'b0;
    step();
    chk("kdrop_hold_kill", 32'(irq_kill_req_o), 32'd1);
    chk("kdrop_hold_valid", 32'(irq_valid_o), 32'd1);
    irq_kill_ack_i = 1'b1;
    #1;
    chk("kdrop_no_ready", 32'(tgt_ready_o), 32'd0);
    step();
    irq_kill_ack_i = 1'b0;
    clr_all();
    chk("kdrop_idle", 32'(irq_valid_o), 32'd0);

    // reset in the middle of KILL
    set_tgt(1, 1'b1, 8'd13, 8'h55, 2'd2);
    push(1'b1, 8'd13, 8'h55, 2'd2);
    step();
    tgt_kill_req_i = 2'b10;
    step();
    chk("rk_kill_req", 32'(irq_kill_req_o), 32'd1);
    rst_i          = 1'b1;
    irq_ready_i    = 1'b1;
    irq_kill_ack_i = 1'b1;
    #1;
    chk("rk_ready_gated", 32'(tgt_ready_o), 32'd0);
    chk("rk_kack_gated", 32'(tgt_kill_ack_o), 32'd0);
    step();
    chk("rk_valid", 32'(irq_valid_o), 32'd0);
    chk("rk_kill", 32'(irq_kill_req_o), 32'd0);
    chk("rk_id", 32'(irq_id_o), 32'd0);
    chk("rk_max", 32'(irq_max_o), 32'd0);
    chk("rk_mode", 32'(irq_mode_o), 32'd0);
    chk("rk_tgt", 32'(irq_tgt_o), 32'd0);
    rst_i          = 1'b0;
    irq_ready_i    = 1'b0;
    irq_kill_ack_i = 1'b0;
    clr_all();
    step();

    // equal requests held across four handshakes
    set_tgt(0, 1'b1, 8'd11, 8'h33, 2'd2);
    set_tgt(1, 1'b1, 8'd22, 8'h33, 2'd2);
    for (int i = 0; i < 4; i++) begin
`ifdef CLIC_TARGET_ARB_RR_EN
      rr_t = 1'(i % 2);
`else
      rr_t = 1'b0;
`endif
      push(rr_t, rr_t ? 8'd22 : 8'd11, 8'h33, 2'd2);
      step();
      chk("rr_nokill", 32'(irq_kill_req_o), 32'd0);
      irq_ready_i = 1'b1;
      #1;
      chk("rr_ready", 32'(tgt_ready_o), rr_t ? 32'd2 : 32'd1);
      step();
      irq_ready_i = 1'b0;
      chk("rr_bubble", 32'(irq_valid_o), 32'd0);
    end
    clr_all();
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
